// File: rtl/chess_sprite_pkg.sv
// Shared sprite constants, the piece-id enum used by the piece controller,
// and the state type of the sprite RAM loader.
package chess_sprite_pkg;

  localparam int SPRITE_W      = 60;
  localparam int SPRITE_H      = 60;
  localparam int NUM_PIECES    = 12;
  localparam int SPRITE_PIXELS = SPRITE_W * SPRITE_H;
  localparam int SPRITE_BYTES  = SPRITE_PIXELS / 2;

  typedef enum logic [3:0] {
    wP, wN, wB, wR, wQ, wK,
    bP, bN, bB, bR, bQ, bK
  } piece_id_e;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    DRAIN
  } loader_state_e;

endpackage

// File: rtl/sprite_ram_loader.sv
// Unpacks a header + packed 4-bit pixel byte stream into per-pixel writes to
// the shared sprite RAM, tracking which sprite slots hold a complete image.
module sprite_ram_loader #(
  parameter int SPRITE_W   = chess_sprite_pkg::SPRITE_W,
  parameter int SPRITE_H   = chess_sprite_pkg::SPRITE_H,
  parameter int NUM_PIECES = chess_sprite_pkg::NUM_PIECES,
  parameter int ADDR_W     = 12
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  output logic                  wr_en,
  output logic [3:0]            wr_piece,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [3:0]            wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [NUM_PIECES-1:0] loaded
);

  import chess_sprite_pkg::loader_state_e;
  import chess_sprite_pkg::IDLE;
  import chess_sprite_pkg::HI;
  import chess_sprite_pkg::LO;
  import chess_sprite_pkg::DRAIN;

  // ptr points at the first pixel of the pair being written; the last pair
  // starts two pixels before the end of the sprite.
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(SPRITE_W * SPRITE_H - 2);

  loader_state_e         state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [3:0]            lo_nib_q, lo_nib_d;
  logic                  last_q, last_d;

  logic                  s_ready_d, wr_en_d, busy_d, done_d, err_d;
  logic [3:0]            wr_piece_d, wr_data_d;
  logic [ADDR_W-1:0]     wr_addr_d;
  logic [NUM_PIECES-1:0] loaded_d;

  logic xfer, hdr_ok, last_pair;

  assign xfer      = s_valid && s_ready;
  assign hdr_ok    = (int'(s_data[3:0]) < NUM_PIECES) && !s_last;
  assign last_pair = (ptr_q == LAST_PAIR);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      lo_nib_q <= '0;
      last_q   <= 1'b0;
      s_ready  <= 1'b0;
      wr_en    <= 1'b0;
      wr_piece <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      loaded   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lo_nib_q <= lo_nib_d;
      last_q   <= last_d;
      s_ready  <= s_ready_d;
      wr_en    <= wr_en_d;
      wr_piece <= wr_piece_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      loaded   <= loaded_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_ok)       state_d = HI;
          else if (!s_last) state_d = DRAIN;
        end
      end
      HI: begin
        if (xfer) state_d = LO;
      end
      LO: begin
        if (last_pair)   state_d = last_q ? IDLE : DRAIN;
        else if (last_q) state_d = IDLE;
        else             state_d = HI;
      end
      DRAIN: begin
        if (xfer && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Computes the next value of every registered output and datapath register,
  // so all outputs are glitch-free flops.
  always_comb begin
    ptr_d      = ptr_q;
    lo_nib_d   = lo_nib_q;
    last_d     = last_q;
    wr_en_d    = 1'b0;
    wr_piece_d = wr_piece;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    done_d     = 1'b0;
    err_d      = 1'b0;
    loaded_d   = loaded;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_ok) begin
            wr_piece_d               = s_data[3:0];
            ptr_d                    = '0;
            loaded_d[s_data[3:0]]    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HI: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = s_data[7:4];
          lo_nib_d  = s_data[3:0];
          last_d    = s_last;
        end
      end
      LO: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q + ADDR_W'(1);
        wr_data_d = lo_nib_q;
        ptr_d     = ptr_q + ADDR_W'(2);
        if (last_pair && last_q) begin
          done_d             = 1'b1;
          loaded_d[wr_piece] = 1'b1;
        end else if (last_pair || last_q) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d    = (state_d != IDLE);
    s_ready_d = (state_d != LO);
  end

endmodule

// File: doc/sprite_ram_loader.md
Name: sprite_ram_loader

Overview:
- Write-side counterpart of the per-piece sprite readers in hdmi_piece_controller.
- Accepts a byte stream carrying one 60x60, 4-bit palette-index sprite and writes it pixel-by-pixel into the shared sprite RAM.
- The draw logic reads that RAM at address (x + y*60), so piece art can be reloaded at runtime instead of being fixed in ROM.
- Sits between the host byte source (UART/AXI-stream bridge) and the sprite RAM write port, in the vga_clk domain.

Parameters:
- SPRITE_W, 60, sprite width in pixels.
- SPRITE_H, 60, sprite height in pixels.
- NUM_PIECES, 12, number of sprite slots; a piece id must be below this.
- ADDR_W, 12, RAM pixel-address width; must satisfy 2^ADDR_W >= SPRITE_W*SPRITE_H.

Ports:
- vga_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader can accept a byte this cycle.
- s_data  in  8  stream byte.
- s_last  in  1  marks the final byte of a frame.
- wr_en  out  1  RAM write strobe.
- wr_piece  out  4  target sprite slot.
- wr_addr  out  ADDR_W  pixel address, 0..SPRITE_W*SPRITE_H-1.
- wr_data  out  4  palette index.
- busy  out  1  a frame is in progress (not IDLE).
- done  out  1  one-cycle pulse when a frame loads successfully.
- err  out  1  one-cycle pulse when a frame is rejected.
- loaded  out  NUM_PIECES  per-slot flag: the slot holds a complete sprite.

Behaviour:
- Clock and reset: one clock, vga_clk; reset_n is asynchronous and active-low.
- Reset values: all outputs are registered and reset to 0. s_ready resets to 0 and rises on the first clock after reset release. The FSM resets to IDLE.
- Frame format:
  - Byte 0 is a header; s_data[3:0] is the piece id and s_data[7:4] is ignored.
  - Then NPB = SPRITE_W*SPRITE_H/2 = 1800 data bytes follow.
  - In each data byte, the high nibble is pixel 2k and the low nibble is pixel 2k+1, in raster order.
  - s_last must be high on data byte NPB only.
- Byte transfer: a byte moves when s_valid && s_ready. s_data and s_last are sampled only on a transfer.
- FSM states: IDLE, HI, LO, DRAIN.
  - IDLE: s_ready=1. A header transfer does the following:
    - If id < NUM_PIECES and s_last=0: latch the id, clear ptr, clear loaded[id], go to HI.
    - If id >= NUM_PIECES or s_last=1: pulse err. If s_last=0, go to DRAIN; otherwise stay in IDLE.
  - HI: s_ready=1. On a transfer at edge t:
    - At edge t+1 the outputs are wr_en=1, wr_addr=ptr, wr_data=s_data[7:4].
    - The low nibble and s_last are latched, and the FSM goes to LO.
  - LO: s_ready=0. At the next edge the outputs are wr_en=1, wr_addr=ptr+1, wr_data=latched low nibble, and ptr advances by 2. The transition depends on whether this byte was byte NPB:
    - Byte NPB with latched last=1: pulse done on this same edge, set loaded[id], go to IDLE.
    - Byte NPB with latched last=0: pulse err, go to DRAIN.
    - Byte before NPB with latched last=1: pulse err (short frame), go to IDLE; loaded[id] stays 0.
    - Otherwise go to HI.
  - DRAIN: s_ready=1. All bytes are discarded with no writes. A transfer with s_last=1 returns the FSM to IDLE.
- Timing:
  - Throughput is 1 byte per 2 cycles, 2 writes per byte.
  - Latency from a data-byte transfer to its first write is 1 cycle.
  - wr_en is 0 in every cycle not listed above.
- Other output rules:
  - wr_piece holds the latched id for the whole frame.
  - busy=1 whenever the state is not IDLE.
  - ptr is an ADDR_W-bit counter and never wraps within a valid frame; the maximum address is 3599.
  - done and err never assert in the same cycle.
- Reset mid-frame: the FSM returns to IDLE immediately and the partial slot's loaded bit stays 0. The RAM contents are not cleared.
- Back-to-back frames: a new header is accepted in the first IDLE cycle after done, with no idle gap required.

Decomposition:
- chess_sprite_pkg holds:
  - the SPRITE_W/SPRITE_H/NUM_PIECES constants;
  - the piece-id enum (wP..bK = 0..11), shared with the piece controller;
  - the loader FSM state typedef.
- No sub-module is needed; the sprite RAM itself is instantiated at the top level, outside this block.

Test Plan:
- Reset, then send header 0x03 followed by 1800 bytes of 0xA5, with s_last on the final byte:
  - The bench sees 3600 writes to piece 3, with addresses 0..3599 in order.
  - Data alternates A,5; done pulses once; loaded = 12'h008.
- Same frame with s_valid toggling every other cycle:
  - Identical write sequence; s_ready never high in LO.
- Header 0x0C followed by 4 bytes, the last with s_last:
  - err pulses on the header edge; no wr_en; the FSM returns to IDLE after the 4th byte; loaded unchanged.
- Header 0x00 followed by 10 bytes, the 10th with s_last:
  - 20 writes; err pulses after the write at address 19; loaded[0]=0.
- Header 0x05 followed by 1800 bytes with no s_last, then 2 extra bytes, the last with s_last:
  - err on the final write; extra bytes are drained; loaded[5]=0.
- Assert reset_n=0 mid-frame at byte 900 of piece 7, then release and send a full piece-7 frame:
  - All outputs read 0 during reset; busy=0.
  - The second frame completes with done and loaded[7]=1.
